// File: rtl/checkpal_axil_slave.sv
// checkpal_axil_slave: AXI4-Lite CheckPalindrome register file and bit-serial engine.
// Optional macro CHECKPAL_IRQ_EN adds a registered irq output (DONE && IE).
module checkpal_axil_slave #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
`ifdef CHECKPAL_IRQ_EN
    ,
    output logic              irq
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] scratch_q;
    logic              ie_q;
    logic [4:0]        len_q;

    logic [DATA_W-1:0] d_q;
    logic [4:0]        lo_q, hi_q, cnt_q, tgt_q;
    logic              pal_q;
    logic              is_pal_q;
    logic [7:0]        cycles_q;

    logic [1:0]        wa, ra;
    logic              wr_hs, rd_hs;
    logic              busy, done;
    logic              start_req, start_go, w1c, wr_err;
    logic [4:0]        len_wr, tgt_wr;
    logic              eq, last;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_ok;

    assign unused_ok = ^{awprot, arprot, awaddr, araddr};

    assign wa = awaddr[3:2];
    assign ra = araddr[3:2];

    // Readies are gated by reset so nothing handshakes while held in reset
    assign wr_hs   = awvalid && wvalid && !bvalid && s00_axi_aresetn;
    assign rd_hs   = arvalid && !rvalid && s00_axi_aresetn;
    assign awready = wr_hs;
    assign wready  = wr_hs;
    assign arready = rd_hs;
    assign rresp   = 2'b00;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    assign start_req = wr_hs && (wa == 2'd1) && wstrb[0] && wdata[0];
    assign start_go  = start_req && !busy;
    assign w1c       = wr_hs && (wa == 2'd2) && wstrb[0] && wdata[1];
    assign wr_err    = busy && (((wa == 2'd0) && (|wstrb)) ||
                                ((wa == 2'd1) && wstrb[1]));

    // START and LEN may arrive in the same CTRL write
    assign len_wr = ((wa == 2'd1) && wstrb[1]) ? wdata[12:8] : len_q;

    // max(1, (len+1)/2) without a wider adder
    always_comb begin
        tgt_wr = {1'b0, len_wr[4:1]} + {4'd0, len_wr[0]};
        if (tgt_wr == 5'd0) tgt_wr = 5'd1;
    end

    assign eq   = (d_q[lo_q] == d_q[hi_q]);
    assign last = ((cnt_q + 5'd1) == tgt_q);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) state <= S_IDLE;
        else                  state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start_req) state_nx = S_RUN;
            S_RUN:  if (last) state_nx = S_DONE;
            S_DONE: begin
                if (start_req) state_nx = S_RUN;
                else if (w1c)  state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            d_q      <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
            tgt_q    <= '0;
            pal_q    <= 1'b0;
            is_pal_q <= 1'b0;
            cycles_q <= '0;
        end else if (start_go) begin
            d_q      <= data_q;
            lo_q     <= '0;
            hi_q     <= len_wr;
            cnt_q    <= '0;
            tgt_q    <= tgt_wr;
            pal_q    <= 1'b1;
            is_pal_q <= 1'b0;
            cycles_q <= '0;
        end else if (busy) begin
            pal_q <= pal_q & eq;
            lo_q  <= lo_q + 5'd1;
            hi_q  <= hi_q - 5'd1;
            cnt_q <= cnt_q + 5'd1;
            if (last) begin
                is_pal_q <= pal_q & eq;
                cycles_q <= {3'd0, cnt_q} + 8'd1;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            data_q    <= '0;
            scratch_q <= '0;
            ie_q      <= 1'b0;
            len_q     <= '0;
            bvalid    <= 1'b0;
            bresp     <= 2'b00;
        end else begin
            if (bvalid && bready) bvalid <= 1'b0;
            if (wr_hs) begin
                bvalid <= 1'b1;
                bresp  <= wr_err ? 2'b10 : 2'b00;
                case (wa)
                    2'd0: begin
                        for (int i = 0; i < 4; i++)
                            if (wstrb[i] && !busy)
                                data_q[8*i +: 8] <= wdata[8*i +: 8];
                    end
                    2'd1: begin
                        if (wstrb[0]) ie_q <= wdata[1];
                        if (wstrb[1] && !busy) len_q <= wdata[12:8];
                    end
                    2'd3: begin
                        for (int i = 0; i < 4; i++)
                            if (wstrb[i])
                                scratch_q[8*i +: 8] <= wdata[8*i +: 8];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (ra)
            2'd0: rd_mux = data_q;
            2'd1: begin
                rd_mux[1]    = ie_q;
                rd_mux[12:8] = len_q;
            end
            2'd2: begin
                rd_mux[0]    = busy;
                rd_mux[1]    = done;
                rd_mux[2]    = is_pal_q;
                rd_mux[15:8] = cycles_q;
            end
            default: rd_mux = scratch_q;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            if (rvalid && rready) rvalid <= 1'b0;
            if (rd_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
            end
        end
    end

`ifdef CHECKPAL_IRQ_EN
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) irq <= 1'b0;
        else                  irq <= done && ie_q;
    end
`endif

endmodule

// File: tb/tb_checkpal_axil_slave.sv
// Bench for checkpal_axil_slave: randomized register and engine traffic
// compared against a behavioural model of the register map.
`timescale 1ns/1ps
module tb_checkpal_axil_slave;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
`ifdef CHECKPAL_IRQ_EN
    logic        irq;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [31:0] pv[$];
    int          pe[$];
    logic [31:0] m_data = '0;
    logic [31:0] m_scr = '0;

    checkpal_axil_slave #(.ADDR_W(4), .DATA_W(32)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rstn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef CHECKPAL_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int tgt_of(input int n);
        return (n / 2 < 1) ? 1 : n / 2;
    endfunction

    // Palindrome test as "low n bits equal their own reversal"
    function automatic logic [31:0] exp_result(input logic [31:0] d, input int n,
                                               input bit done);
        logic [31:0] rev;
        logic [31:0] mask;
        logic        pal;
        rev = '0;
        for (int i = 0; i < n; i++) rev[n-1-i] = d[i];
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        pal = ((d & mask) == rev);
        return {16'd0, 8'(tgt_of(n)), 5'd0, pal, done, 1'b0};
    endfunction

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp,
                             output int hs);
        bit got;
        resp = 2'bxx;
        hs = -1;
        got = 1'b0;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (awready && wready) begin got = 1'b1; hs = cyc + 1; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        if (!got) begin
            n_chk++;
            $display("FAIL write_accept: addr %h got no awready, want accept", a);
        end else begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (bvalid) begin got = 1'b1; resp = bresp; end
            end
            if (!got) begin
                n_chk++;
                $display("FAIL write_bvalid: addr %h got no bvalid, want bvalid", a);
            end
        end
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output int hs);
        bit got;
        d = 'x;
        resp = 2'bxx;
        hs = -1;
        got = 1'b0;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (arready) begin got = 1'b1; hs = cyc + 1; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        if (!got) begin
            n_chk++;
            $display("FAIL read_accept: addr %h got no arready, want accept", a);
        end else begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (rvalid) begin got = 1'b1; d = rdata; resp = rresp; end
            end
            if (!got) begin
                n_chk++;
                $display("FAIL read_rvalid: addr %h got no rvalid, want rvalid", a);
            end
        end
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic poll_result();
        logic [31:0] v;
        logic [1:0]  r;
        int          e;
        pv.delete();
        pe.delete();
        for (int i = 0; i < 40; i++) begin
            axi_read(4'h8, v, r, e);
            pv.push_back(v);
            pe.push_back(e);
            if (v[0] === 1'b0) break;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [1:0]  r;
        int          e;
        #100;
        n_chk++;
        if ({awready, wready, bvalid, arready, rvalid, bresp, rdata} !== '0)
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%b bresp %b rdata %h want all 0",
                     awready, wready, bvalid, arready, rvalid, bresp, rdata);
        else n_pass++;
        #100;
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            axi_read(4'(k * 4), v, r, e);
            n_chk++;
            if ({r, v} !== 34'd0)
                $display("FAIL reset_read: addr %0h got rresp %b data %h want 00/0", k * 4, r, v);
            else n_pass++;
        end
    endtask

    task automatic test_regs();
        logic [31:0] v;
        logic [31:0] exp[4];
        logic [1:0]  r;
        int          e;
        exp = '{32'h1, 32'h2, 32'h0, 32'h4};
        for (int k = 0; k < 4; k++) begin
            axi_write(4'(k * 4), 32'(k + 1), 4'hF, r, e);
            n_chk++;
            if (r !== 2'b00) $display("FAIL regs_bresp: addr %0h got %b want 00", k * 4, r);
            else n_pass++;
        end
        m_data = 32'h1;
        m_scr = 32'h4;
        for (int k = 0; k < 4; k++) begin
            axi_read(4'(k * 4), v, r, e);
            n_chk++;
            if (v !== exp[k] || r !== 2'b00)
                $display("FAIL regs_read: addr %0h got %h/%b want %h/00", k * 4, v, r, exp[k]);
            else n_pass++;
        end
    endtask

    task automatic test_strobe();
        logic [31:0] v, d;
        logic [3:0]  a, s;
        logic [1:0]  r;
        int          e;
        axi_write(4'hC, 32'h0, 4'hF, r, e);
        axi_write(4'hC, 32'hFFFF_FFFF, 4'b0101, r, e);
        m_scr = 32'h00FF_00FF;
        axi_read(4'hC, v, r, e);
        n_chk++;
        if (v !== 32'h00FF_00FF) $display("FAIL strobe_0101: got %h want 00ff00ff", v);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            a = $urandom_range(0, 1) ? 4'hC : 4'h0;
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            axi_write(a, d, s, r, e);
            for (int b = 0; b < 4; b++) begin
                if (s[b] && a == 4'hC) m_scr[8*b +: 8] = d[8*b +: 8];
                if (s[b] && a == 4'h0) m_data[8*b +: 8] = d[8*b +: 8];
            end
            axi_read(a, v, r, e);
            n_chk++;
            if (v !== ((a == 4'hC) ? m_scr : m_data))
                $display("FAIL strobe_rand: addr %h strb %b got %h want %h",
                         a, s, v, (a == 4'hC) ? m_scr : m_data);
            else n_pass++;
        end
    endtask

    task automatic test_engine();
        logic [31:0] d, v, ex;
        logic [1:0]  r;
        int          n, s, t, e;
        for (int k = 0; k < 14; k++) begin
            if (k == 0) begin d = 32'h81; n = 8; end
            else if (k == 1) begin d = 32'h82; n = 8; end
            else if (k == 2) begin d = $urandom; n = 1; end
            else begin
                n = $urandom_range(1, 32);
                d = $urandom;
                if ($urandom_range(0, 1) == 1)
                    for (int i = 0; i < n / 2; i++) d[n-1-i] = d[i];
            end
            axi_write(4'h0, d, 4'hF, r, e);
            m_data = d;
            axi_write(4'h4, 32'((n - 1) << 8) | 32'h1, 4'hF, r, s);
            n_chk++;
            if (r !== 2'b00) $display("FAIL engine_start_bresp: got %b want 00", r);
            else n_pass++;
            t = tgt_of(n);
            ex = exp_result(d, n, 1'b1);
            poll_result();
            foreach (pv[j]) begin
                n_chk++;
                if (pe[j] - s <= t) begin
                    if (pv[j][1:0] !== 2'b01)
                        $display("FAIL engine_busy: n=%0d edge+%0d got %h want busy", n, pe[j] - s, pv[j]);
                    else n_pass++;
                end else if (pv[j] !== ex)
                    $display("FAIL engine_result: d=%h n=%0d edge+%0d got %h want %h",
                             d, n, pe[j] - s, pv[j], ex);
                else n_pass++;
            end
            n_chk++;
            if (pv.size() == 0 || pv[pv.size()-1][0] !== 1'b0)
                $display("FAIL engine_finish: n=%0d got still busy want done", n);
            else n_pass++;
            if (k < 2 || $urandom_range(0, 1) == 1) begin
                axi_write(4'h8, 32'h2, 4'h1, r, e);
                axi_read(4'h8, v, r, e);
                n_chk++;
                if (v !== exp_result(d, n, 1'b0))
                    $display("FAIL engine_w1c: got %h want %h", v, exp_result(d, n, 1'b0));
                else n_pass++;
            end
        end
    endtask

    task automatic test_busy_err();
        logic [31:0] v, ex;
        logic [1:0]  r, xr;
        int          s, e, t, hd, hl;
        axi_write(4'h0, 32'h8000_0001, 4'hF, r, e);
        m_data = 32'h8000_0001;
        axi_write(4'h4, 32'h0000_1F01, 4'hF, r, s);
        t = 16;
        axi_write(4'h0, 32'h0, 4'hF, xr, hd);
        n_chk++;
        if (xr !== ((hd - s <= t) ? 2'b10 : 2'b00))
            $display("FAIL busy_data_bresp: got %b want %b", xr, (hd - s <= t) ? 2'b10 : 2'b00);
        else n_pass++;
        if (hd - s > t) m_data = 32'h0;
        axi_write(4'h4, 32'h0000_0003, 4'h1, r, e);
        n_chk++;
        if (r !== 2'b00) $display("FAIL busy_start_bresp: got %b want 00", r);
        else n_pass++;
        axi_write(4'h4, 32'h0000_0000, 4'h2, xr, hl);
        n_chk++;
        if (xr !== ((hl - s <= t) ? 2'b10 : 2'b00))
            $display("FAIL busy_len_bresp: got %b want %b", xr, (hl - s <= t) ? 2'b10 : 2'b00);
        else n_pass++;
        poll_result();
        ex = exp_result(32'h8000_0001, 32, 1'b1);
        foreach (pv[j]) begin
            n_chk++;
            if (pe[j] - s <= t) begin
                if (pv[j][1:0] !== 2'b01)
                    $display("FAIL busy_poll: edge+%0d got %h want busy", pe[j] - s, pv[j]);
                else n_pass++;
            end else if (pv[j] !== ex)
                $display("FAIL busy_result: edge+%0d got %h want %h", pe[j] - s, pv[j], ex);
            else n_pass++;
        end
        axi_read(4'h0, v, r, e);
        n_chk++;
        if (v !== m_data) $display("FAIL busy_data_keep: got %h want %h", v, m_data);
        else n_pass++;
        axi_read(4'h4, v, r, e);
        n_chk++;
        if (v !== 32'h0000_1F02) $display("FAIL busy_ctrl: got %h want 00001f02", v);
        else n_pass++;
    endtask

    task automatic test_w1c_race();
        logic [31:0] v;
        logic [1:0]  r;
        int          s, e, t;
        axi_write(4'h8, 32'h2, 4'h1, r, e);
        axi_write(4'h4, 32'h0000_1F01, 4'hF, r, s);
        t = 16;
        for (int i = 0; i < 40 && cyc < s + t - 2; i++) @(negedge clk);
        axi_write(4'h8, 32'h2, 4'h1, r, e);
        n_chk++;
        if (e !== s + t) $display("FAIL race_timing: got edge+%0d want edge+%0d", e - s, t);
        else n_pass++;
        axi_read(4'h8, v, r, e);
        n_chk++;
        if (v !== 32'h0000_1006) $display("FAIL race_done_wins: got %h want 00001006", v);
        else n_pass++;
        axi_write(4'h8, 32'h2, 4'h1, r, e);
        axi_read(4'h8, v, r, e);
        n_chk++;
        if (v !== 32'h0000_1004) $display("FAIL race_w1c: got %h want 00001004", v);
        else n_pass++;
    endtask

    task automatic test_irq();
        logic [31:0] v;
        logic [1:0]  r;
        int          e;
        axi_write(4'h0, 32'h81, 4'hF, r, e);
        m_data = 32'h81;
        axi_write(4'h4, 32'h0000_0703, 4'hF, r, e);
        poll_result();
        n_chk++;
        if (pv.size() == 0 || pv[pv.size()-1] !== 32'h406)
            $display("FAIL irq_result: got %h want 00000406",
                     (pv.size() == 0) ? 32'hx : pv[pv.size()-1]);
        else n_pass++;
`ifdef CHECKPAL_IRQ_EN
        @(negedge clk);
        n_chk++;
        if (irq !== 1'b1) $display("FAIL irq_assert: got %b want 1", irq);
        else n_pass++;
        axi_write(4'h8, 32'h2, 4'h1, r, e);
        n_chk++;
        if (irq !== 1'b0) $display("FAIL irq_w1c: got %b want 0", irq);
        else n_pass++;
        axi_write(4'h4, 32'h0000_0703, 4'hF, r, e);
        poll_result();
        @(negedge clk);
        n_chk++;
        if (irq !== 1'b1) $display("FAIL irq_reassert: got %b want 1", irq);
        else n_pass++;
        axi_write(4'h4, 32'h0000_0000, 4'h1, r, e);
        n_chk++;
        if (irq !== 1'b0) $display("FAIL irq_ie_clear: got %b want 0", irq);
        else n_pass++;
`endif
        axi_read(4'h8, v, r, e);
        n_chk++;
        if (v[1] !== 1'b1 && v[0] !== 1'b0) $display("FAIL irq_done_state: got %h want done", v);
        else n_pass++;
        axi_write(4'h8, 32'h2, 4'h1, r, e);
    endtask

    task automatic test_bready_hold();
        logic [31:0] v;
        logic [1:0]  r;
        int          e;
        bit          got;
        @(posedge clk); #1;
        awaddr = 4'hC; wdata = 32'h1111_1111; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = awready && wready;
        end
        @(posedge clk); #1;
        wdata = 32'h2222_2222;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_chk++;
            if (!got || bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0)
                $display("FAIL bready_hold: cyc %0d got bvalid %b awready %b wready %b want 1/0/0",
                         i, bvalid, awready, wready);
            else n_pass++;
        end
        @(posedge clk); #1;
        bready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = awready && wready;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        bready = 1'b0;
        m_scr = 32'h2222_2222;
        n_chk++;
        if (!got) $display("FAIL bready_second: got no accept want accept");
        else n_pass++;
        @(posedge clk); #1;
        araddr = 4'hC; arvalid = 1'b1; rready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = arready;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk++;
            if (rvalid !== 1'b1 || rdata !== m_scr)
                $display("FAIL rready_hold: cyc %0d got %b/%h want 1/%h", i, rvalid, rdata, m_scr);
            else n_pass++;
        end
        @(posedge clk); #1;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        n_chk++;
        if (rvalid !== 1'b0) $display("FAIL rready_release: got %b want 0", rvalid);
        else n_pass++;
        axi_read(4'h0, v, r, e);
    endtask

    task automatic test_concurrent();
        logic [31:0] v, d;
        logic [1:0]  wr, rr;
        int          we, re;
        d = $urandom;
        fork
            axi_write(4'hC, d, 4'hF, wr, we);
            axi_read(4'h0, v, rr, re);
        join
        n_chk++;
        if (wr !== 2'b00 || v !== m_data)
            $display("FAIL concurrent: got bresp %b data %h want 00/%h", wr, v, m_data);
        else n_pass++;
        m_scr = d;
        axi_read(4'hC, v, rr, re);
        n_chk++;
        if (v !== m_scr) $display("FAIL concurrent_scratch: got %h want %h", v, m_scr);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        logic [31:0] v;
        logic [1:0]  r;
        int          e;
        axi_write(4'h0, 32'h8000_0001, 4'hF, r, e);
        axi_write(4'h4, 32'h0000_1F03, 4'hF, r, e);
        @(posedge clk); #1;
        araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        n_chk++;
        if (rvalid !== 1'b1) $display("FAIL midrun_pre: got rvalid %b want 1", rvalid);
        else n_pass++;
        #1 rstn = 1'b0;
        #1;
        n_chk++;
        if ({awready, wready, bvalid, arready, rvalid, bresp, rdata} !== '0)
            $display("FAIL midrun_reset: got %b/%b/%b/%b/%b bresp %b rdata %h want all 0",
                     awready, wready, bvalid, arready, rvalid, bresp, rdata);
        else n_pass++;
`ifdef CHECKPAL_IRQ_EN
        n_chk++;
        if (irq !== 1'b0) $display("FAIL midrun_irq: got %b want 0", irq);
        else n_pass++;
`endif
        arvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        m_data = '0;
        m_scr = '0;
        for (int k = 0; k < 4; k++) begin
            axi_read(4'(k * 4), v, r, e);
            n_chk++;
            if (v !== 32'h0) $display("FAIL midrun_read: addr %0h got %h want 0", k * 4, v);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_strobe();
        test_engine();
        test_busy_err();
        test_w1c_race();
        test_irq();
        test_bready_hold();
        test_concurrent();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/checkpal_axil_slave.md
Name: checkpal_axil_slave

Overview:
- AXI4-Lite slave (S00_AXI port) holding the CheckPalindrome register file, plus a bit-serial palindrome engine.
- Responds to the master agent's AXI4LITE_WRITE_BURST/READ_BURST single-beat transfers.
- Software loads a data word and length, sets START, then polls RESULT.
- Sits between the block-design AXI interconnect and the palindrome datapath.

Parameters:
- ADDR_W, 4, byte-address width; bits [3:2] select one of 4 word registers; bits [1:0] ignored.
- DATA_W, 32, AXI data width; only 32 is supported.

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  asynchronous active-low reset
- awaddr  in  ADDR_W  write address
- awprot  in  3  ignored
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response: 00 OKAY, 10 SLVERR
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_W  read address
- arprot  in  3  ignored
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  always 00
- rvalid  out  1  read data valid
- rready  in  1  read data ready

Behaviour:
- Reset (aresetn low, asynchronous, any time including mid-run): all ready/valid outputs 0; bresp=0, rdata=0; all registers 0; engine returns to IDLE.
- Register map:
  - 0x0 DATA: RW, 32 bits.
  - 0x4 CTRL: RW. [0] START, self-clears next cycle and always reads 0. [1] IE. [12:8] LEN-1, so length is 1..32.
  - 0x8 RESULT: RO. [0] BUSY, [1] DONE (W1C), [2] IS_PAL, [15:8] CYCLES. Writes to other bits are ignored with OKAY.
  - 0xC SCRATCH: RW, no side effects.
- Write channel:
  - awready and wready pulse high together for one cycle when awvalid && wvalid && !bvalid.
  - Register updates in that cycle, honouring wstrb per byte.
  - bvalid rises the next cycle and holds until bready; no new write is accepted while bvalid=1.
  - AW without W (or W without AW) waits; neither is accepted alone.
- Read channel:
  - arready pulses for one cycle when arvalid && !rvalid.
  - rdata is captured from the register value in that cycle.
  - rvalid rises the next cycle and holds, with rdata stable, until rready.
  - Read and write channels operate independently and concurrently.
- Engine FSM:
  - IDLE -> RUN on START=1 write.
    - Latch D=DATA and N=LEN.
    - lo=0, hi=N-1, pal=1, cnt=0.
    - Set BUSY=1, DONE=0.
  - RUN, each cycle:
    - pal &= (D[lo]==D[hi]); lo++, hi--; cnt++.
    - Exit when cnt reaches max(1, N/2) (integer divide).
    - Latency is deterministic; no early exit on mismatch.
  - RUN -> DONE: BUSY=0, DONE=1, IS_PAL=pal, CYCLES=cnt.
  - DONE -> RUN on a new START (clears DONE). DONE -> IDLE when DONE is cleared by W1C.
- Boundary cases:
  - START written while BUSY: ignored, response OKAY.
  - DATA or CTRL[12:8] written while BUSY: register unchanged, bresp=SLVERR. The SCRATCH and IE bits still follow normal rules.
  - W1C of DONE in the same cycle as engine completion: completion wins, DONE=1.
  - LEN=1: one cycle, IS_PAL=1.

Optional Feature:
- Macro CHECKPAL_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, reset 0), registered.
  - irq = DONE && IE.
  - Deasserts the cycle after DONE is W1C-cleared or IE is written 0.
- Undefined:
  - No irq port.
  - IE bit is storage only, readable and writable, with no effect.

Test Plan:
- Release reset at 200 ns, read 0x0/0x4/0x8/0xC -> all 0x00000000, rresp=00.
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back:
  - 0x0 -> 0x1.
  - 0xC -> 0x4.
  - 0x4 -> 0x00000002 (START self-cleared, IE=1).
  - 0x8 -> 0x0 (RO).
  - All bresp=00.
- DATA=0x00000081, CTRL=0x00000701 (LEN=8):
  - BUSY=1 for exactly 4 cycles.
  - Then RESULT=0x00000406 (DONE, IS_PAL, CYCLES=4).
  - With CHECKPAL_IRQ_EN and IE=1, irq=1 until W1C of 0x2 to 0x8.
- DATA=0x00000082, LEN=8 -> RESULT=0x00000402 (not palindrome).
- LEN=32, DATA=0x80000001:
  - Write DATA=0 while BUSY -> bresp=10, DATA still reads 0x80000001.
  - Final RESULT=0x00001006.
- Write 0xFFFFFFFF to 0xC with wstrb=0b0101 -> reads 0x00FF00FF.
- Assert reset mid-RUN -> RESULT=0 and all valids 0 immediately.
- Hold bready=0 for 10 cycles -> bvalid stays 1 and a second AW/W stays unaccepted.
